lcd_receiver: RTL and testbench
===============================

LCD_RECEIVER -- requirements
Module: lcd_receiver

Interface
REQ-001 The block SHALL have no parameters; widths SHALL be fixed as listed below.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 en_i  input  1  panel enable strobe; a transaction completes on its falling edge.
REQ-005 rw_i  input  1  1 = read, 0 = write.
REQ-006 dori_i  input  1  1 = data, 0 = instruction.
REQ-007 db_i  input  8  panel data bus.
REQ-008 cs_i  input  2  active-high chip selects; bit0 = left chip, bit1 = right chip.
REQ-009 rst_i  input  1  panel reset, active-high.
REQ-010 wr_en_o  output  1  one-cycle display-RAM write strobe.
REQ-011 wr_addr_o  output  10  {chip, page[2:0], y[5:0]}.
REQ-012 wr_data_o  output  8  write data.
REQ-013 disp_on_o  output  2  per-chip display-on flag.
REQ-014 start0_o / start1_o  output  6 each  per-chip display start line.
REQ-015 status_o  output  8  status byte: {1'b0, 1'b0, ~on, rst_i, 4'b0000}, for the lowest selected chip; 0x00 when cs_i = 00.
REQ-016 illegal_o  output  1  one-cycle pulse when an unrecognised instruction completes.

Function
REQ-017 Sampling:
- en_i SHALL be registered into en_q.
- rw_i, dori_i, db_i and cs_i SHALL be captured on every edge where en_i = 1.
- A transaction SHALL execute at the edge where en_q = 1 and en_i = 0, using the captured values.
REQ-018 Outputs SHALL be registered; wr_en_o and illegal_o SHALL be high during the cycle following the executing edge.
REQ-019 Per-chip state SHALL comprise page (3b), y (6b), on (1b) and start (6b).
REQ-020 Instruction write (rw = 0, dori = 0), applied to every selected chip:
- 0011111d: on = d.
- 01yyyyyy: y = yyyyyy.
- 10111ppp: page = ppp.
- 11zzzzzz: start = zzzzzz.
- Any other code: illegal_o pulse, no state change.
REQ-021 Data write (rw = 0, dori = 1) to a single chip c:
- wr_en_o = 1, wr_addr_o = {c, page_c, y_c}, wr_data_o = captured db.
- y_c SHALL then increment.
REQ-022 y SHALL wrap 63 -> 0; page SHALL never change on data access.
REQ-023 Data write with cs = 11:
- Chip 0 write SHALL issue in cycle +1 and chip 1 write in cycle +2.
- Each write SHALL use that chip's own page and y; both y counters SHALL increment.
REQ-024 Data read (rw = 1, dori = 1) SHALL increment y of each selected chip and SHALL issue no write.
REQ-025 Status read (rw = 1, dori = 0) SHALL change no state.
REQ-026 cs = 00 at the executing edge SHALL make the transaction a no-op, with no illegal_o pulse.
REQ-027 en_i is guaranteed high for at least 1 cycle and low for at least 1 cycle, so executing edges are at least 2 cycles apart.
REQ-028 A pending second write (REQ-023) SHALL complete before the next transaction executes.
REQ-029 While rst_i = 1:
- All per-chip state SHALL be forced to reset values.
- Executing edges SHALL be ignored.
- status_o[4] SHALL be 1.
- Any pending second write SHALL be cancelled.
REQ-030 wr_addr_o and wr_data_o SHALL hold their last values when wr_en_o = 0.

Reset
REQ-031 With rstn = 0 at a clock edge:
- en_q, wr_en_o, illegal_o, the pending-write flag and all captured fields SHALL become 0.
- page, y, on and start SHALL become 0 for both chips.
- wr_addr_o and wr_data_o SHALL become 0.
REQ-032 rstn asserted mid-transaction or mid-dual-write SHALL discard the transaction, and no write SHALL follow after release.
REQ-033 After reset, disp_on_o = 00, start0_o = start1_o = 0, status_o = 0x20 for a selected chip.

Verification
REQ-034 Sequence cs = 01: 0xB8+3, then 0x40+5, then data 0xA5 -> wr_en_o one cycle, wr_addr_o = 0_011_000101, wr_data_o = 0xA5; y0 = 6.
REQ-035 cs = 10: y set to 63, then two data writes 0x11 and 0x22 -> addresses 1_000_111111 then 1_000_000000.
REQ-036 cs = 11: instruction 0x3F, then data 0x7E -> disp_on_o = 11; writes 0_000_000000 then 1_000_000000 on consecutive cycles; both y = 1.
REQ-037 cs = 01: 0xC0+17 -> start0_o = 17, start1_o = 0; instruction 0x00 -> illegal_o pulses once; cs = 00 with data -> no wr_en_o.
REQ-038 rst_i = 1 during a data write -> no wr_en_o; status_o = 0x30; after rst_i = 0, status_o = 0x20 and y = 0.
REQ-039 rstn pulled low one cycle after a cs = 11 data falling edge -> only the chip 0 write (or none) appears, and all outputs are 0 after release.

Source files
------------

// File: rtl/lcd_receiver_if.sv
// lcd_receiver_if: panel bus plus display-RAM write port of the LCD receiver
//   master: drives the panel strobes, bus and chip selects; observes results
//   slave : the receiver; samples the panel side, drives RAM writes and status
interface lcd_receiver_if;
   logic       en_i;
   logic       rw_i;
   logic       dori_i;
   logic [7:0] db_i;
   logic [1:0] cs_i;
   logic       rst_i;
   logic       wr_en_o;
   logic [9:0] wr_addr_o;
   logic [7:0] wr_data_o;
   logic [1:0] disp_on_o;
   logic [5:0] start0_o;
   logic [5:0] start1_o;
   logic [7:0] status_o;
   logic       illegal_o;
   modport master (
      output en_i, rw_i, dori_i, db_i, cs_i, rst_i,
      input  wr_en_o, wr_addr_o, wr_data_o, disp_on_o, start0_o, start1_o, status_o, illegal_o
   );
   modport slave (
      input  en_i, rw_i, dori_i, db_i, cs_i, rst_i,
      output wr_en_o, wr_addr_o, wr_data_o, disp_on_o, start0_o, start1_o, status_o, illegal_o
   );
endinterface

// File: rtl/lcd_receiver.sv
// lcd_receiver: decodes a two-chip graphic LCD panel bus into display-RAM writes
//   clk  : single rising-edge clock
//   rstn : synchronous active-low reset
//   bus  : panel strobe/bus/selects in; RAM write strobe, address, data,
//          per-chip display-on and start line, status byte, illegal pulse out
module lcd_receiver (
   input logic         clk,
   input logic         rstn,
   lcd_receiver_if.slave bus
);
   logic       en_q, en_d;
   logic       rw_q, rw_d;
   logic       dori_q, dori_d;
   logic [7:0] db_q, db_d;
   logic [1:0] cs_q, cs_d;
   logic       pend_q, pend_d;
   logic       wr_en_q, wr_en_d;
   logic [9:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       illegal_q, illegal_d;
   logic [2:0] page_q[2], page_d[2];
   logic [5:0] y_q[2], y_d[2];
   logic       on_q[2], on_d[2];
   logic [5:0] start_q[2], start_d[2];
   logic       exec;
   logic       dc;
   logic       sc;
   // falling edge of the enable strobe, suppressed while the panel is in reset
   assign exec = en_q & ~bus.en_i & ~bus.rst_i;
   // lowest selected chip of the captured (data write) and live (status) selects
   assign dc = ~cs_q[0];
   assign sc = ~bus.cs_i[0];
   always_comb begin
      en_d      = bus.en_i;
      rw_d      = bus.en_i ? bus.rw_i : rw_q;
      dori_d    = bus.en_i ? bus.dori_i : dori_q;
      db_d      = bus.en_i ? bus.db_i : db_q;
      cs_d      = bus.en_i ? bus.cs_i : cs_q;
      pend_d    = 1'b0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      illegal_d = 1'b0;
      page_d    = page_q;
      y_d       = y_q;
      on_d      = on_q;
      start_d   = start_q;
      if (bus.rst_i) begin
         for (int c = 0; c < 2; c++) begin
            page_d[c]  = 3'd0;
            y_d[c]     = 6'd0;
            on_d[c]    = 1'b0;
            start_d[c] = 6'd0;
         end
      end else begin
         // second half of a dual-chip data write; captured fields are still
         // those of the transaction that scheduled it
         if (pend_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {1'b1, page_q[1], y_q[1]};
            wr_data_d = db_q;
            y_d[1]    = y_q[1] + 6'd1;
         end
         if (exec && cs_q != 2'b00) begin
            if (!rw_q && !dori_q) begin
               if (db_q[7:1] == 7'b0011111) begin
                  for (int c = 0; c < 2; c++) if (cs_q[c]) on_d[c] = db_q[0];
               end else if (db_q[7:6] == 2'b01) begin
                  for (int c = 0; c < 2; c++) if (cs_q[c]) y_d[c] = db_q[5:0];
               end else if (db_q[7:3] == 5'b10111) begin
                  for (int c = 0; c < 2; c++) if (cs_q[c]) page_d[c] = db_q[2:0];
               end else if (db_q[7:6] == 2'b11) begin
                  for (int c = 0; c < 2; c++) if (cs_q[c]) start_d[c] = db_q[5:0];
               end else begin
                  illegal_d = 1'b1;
               end
            end else if (!rw_q && dori_q) begin
               wr_en_d   = 1'b1;
               wr_addr_d = {dc, page_q[dc], y_q[dc]};
               wr_data_d = db_q;
               y_d[dc]   = y_q[dc] + 6'd1;
               pend_d    = &cs_q;
            end else if (rw_q && dori_q) begin
               for (int c = 0; c < 2; c++) if (cs_q[c]) y_d[c] = y_q[c] + 6'd1;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         en_q      <= 1'b0;
         rw_q      <= 1'b0;
         dori_q    <= 1'b0;
         db_q      <= 8'd0;
         cs_q      <= 2'd0;
         pend_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= 10'd0;
         wr_data_q <= 8'd0;
         illegal_q <= 1'b0;
         for (int c = 0; c < 2; c++) begin
            page_q[c]  <= 3'd0;
            y_q[c]     <= 6'd0;
            on_q[c]    <= 1'b0;
            start_q[c] <= 6'd0;
         end
      end else begin
         en_q      <= en_d;
         rw_q      <= rw_d;
         dori_q    <= dori_d;
         db_q      <= db_d;
         cs_q      <= cs_d;
         pend_q    <= pend_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         illegal_q <= illegal_d;
         page_q    <= page_d;
         y_q       <= y_d;
         on_q      <= on_d;
         start_q   <= start_d;
      end
   end
   assign bus.wr_en_o   = wr_en_q;
   assign bus.wr_addr_o = wr_addr_q;
   assign bus.wr_data_o = wr_data_q;
   assign bus.illegal_o = illegal_q;
   assign bus.disp_on_o = {on_q[1], on_q[0]};
   assign bus.start0_o  = start_q[0];
   assign bus.start1_o  = start_q[1];
   assign bus.status_o  = (bus.cs_i == 2'b00) ? 8'h00 : {2'b00, ~on_q[sc], bus.rst_i, 4'b0000};
endmodule

// File: tb/tb_lcd_receiver.sv
// tb_lcd_receiver: directed self-checking bench for lcd_receiver
module tb_lcd_receiver;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   lcd_receiver_if bus ();
   lcd_receiver dut (.clk(clk), .rstn(rstn), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // one panel transaction; returns #1 after the executing edge
   task automatic xact(input logic rw, input logic dori, input logic [7:0] db, input logic [1:0] cs);
      @(negedge clk);
      bus.rw_i = rw; bus.dori_i = dori; bus.db_i = db; bus.cs_i = cs; bus.en_i = 1'b1;
      @(negedge clk);
      bus.en_i = 1'b0;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus.en_i = 0; bus.rw_i = 0; bus.dori_i = 0; bus.db_i = 0; bus.cs_i = 2'b01; bus.rst_i = 0;
      do_reset();
      step();
      check("rst_wr_en", bus.wr_en_o, 0);
      check("rst_illegal", bus.illegal_o, 0);
      check("rst_addr", bus.wr_addr_o, 0);
      check("rst_data", bus.wr_data_o, 0);
      check("rst_disp_on", bus.disp_on_o, 0);
      check("rst_start0", bus.start0_o, 0);
      check("rst_start1", bus.start1_o, 0);
      check("rst_status", bus.status_o, 8'h20);
      bus.cs_i = 2'b00; #1;
      check("status_cs00", bus.status_o, 8'h00);
      // page 3, y 5, write A5 to chip 0
      xact(0, 0, 8'hBB, 2'b01);
      xact(0, 0, 8'h45, 2'b01);
      xact(0, 1, 8'hA5, 2'b01);
      check("w0_en", bus.wr_en_o, 1);
      check("w0_addr", bus.wr_addr_o, 10'b0_011_000101);
      check("w0_data", bus.wr_data_o, 8'hA5);
      step();
      check("w0_en_off", bus.wr_en_o, 0);
      check("w0_addr_hold", bus.wr_addr_o, 10'b0_011_000101);
      check("w0_data_hold", bus.wr_data_o, 8'hA5);
      xact(0, 1, 8'h5A, 2'b01);
      check("w0_y6", bus.wr_addr_o, 10'b0_011_000110);
      // chip 1 y wraps 63 -> 0
      xact(0, 0, 8'h7F, 2'b10);
      xact(0, 1, 8'h11, 2'b10);
      check("w1_y63", bus.wr_addr_o, 10'b1_000_111111);
      check("w1_d11", bus.wr_data_o, 8'h11);
      xact(0, 1, 8'h22, 2'b10);
      check("w1_wrap", bus.wr_addr_o, 10'b1_000_000000);
      check("w1_d22", bus.wr_data_o, 8'h22);
      // dual chip on + dual write
      do_reset();
      xact(0, 0, 8'h3F, 2'b11);
      check("dual_on", bus.disp_on_o, 2'b11);
      check("status_on", bus.status_o, 8'h00);
      xact(0, 1, 8'h7E, 2'b11);
      check("dual_en1", bus.wr_en_o, 1);
      check("dual_addr1", bus.wr_addr_o, 10'b0_000_000000);
      check("dual_data1", bus.wr_data_o, 8'h7E);
      step();
      check("dual_en2", bus.wr_en_o, 1);
      check("dual_addr2", bus.wr_addr_o, 10'b1_000_000000);
      check("dual_data2", bus.wr_data_o, 8'h7E);
      step();
      check("dual_en_off", bus.wr_en_o, 0);
      xact(0, 1, 8'h01, 2'b01);
      check("dual_y0", bus.wr_addr_o, 10'b0_000_000001);
      xact(0, 1, 8'h02, 2'b10);
      check("dual_y1", bus.wr_addr_o, 10'b1_000_000001);
      // start line, display off, illegal, no-op, reads
      xact(0, 0, 8'hD1, 2'b01);
      check("start0", bus.start0_o, 6'd17);
      check("start1", bus.start1_o, 6'd0);
      xact(0, 0, 8'h3E, 2'b01);
      check("off0", bus.disp_on_o, 2'b10);
      check("status_off", bus.status_o, 8'h20);
      xact(0, 0, 8'h00, 2'b01);
      check("illegal_on", bus.illegal_o, 1);
      step();
      check("illegal_off", bus.illegal_o, 0);
      xact(0, 0, 8'h00, 2'b00);
      check("cs00_illegal", bus.illegal_o, 0);
      xact(0, 1, 8'h33, 2'b00);
      check("cs00_wr", bus.wr_en_o, 0);
      xact(1, 0, 8'h00, 2'b01);
      check("stat_rd_wr", bus.wr_en_o, 0);
      xact(1, 1, 8'h00, 2'b01);
      check("data_rd_wr", bus.wr_en_o, 0);
      xact(0, 1, 8'h44, 2'b01);
      check("rd_incr_y", bus.wr_addr_o, 10'b0_000_000011);
      // panel reset
      @(negedge clk); bus.rst_i = 1'b1;
      xact(0, 1, 8'h55, 2'b01);
      check("prst_no_wr", bus.wr_en_o, 0);
      step();
      check("prst_no_wr2", bus.wr_en_o, 0);
      check("prst_status", bus.status_o, 8'h30);
      @(negedge clk); bus.rst_i = 1'b0; #1;
      check("prst_status_rel", bus.status_o, 8'h20);
      check("prst_start0", bus.start0_o, 0);
      check("prst_disp", bus.disp_on_o, 0);
      xact(0, 1, 8'h66, 2'b01);
      check("prst_y0", bus.wr_addr_o, 10'b0_000_000000);
      // rstn during a dual write
      xact(0, 1, 8'h99, 2'b11);
      check("rstn_w0", bus.wr_en_o, 1);
      rstn = 1'b0;
      step();
      check("rstn_cancel", bus.wr_en_o, 0);
      @(negedge clk); rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("rstn_no_wr", bus.wr_en_o, 0);
      end
      check("rstn_addr", bus.wr_addr_o, 0);
      check("rstn_data", bus.wr_data_o, 0);
      check("rstn_disp", bus.disp_on_o, 0);
      check("rstn_illegal", bus.illegal_o, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
